// File: rtl/multicycle_control_fsm.sv
// Main control unit of a multicycle CPU: a Moore FSM that sequences the shared
// datapath one instruction at a time and stalls on the memory ready handshake.
module multicycle_control_fsm #(
  parameter int              OP_W     = 6,
  parameter logic [OP_W-1:0] OP_RTYPE = 6'h00,
  parameter logic [OP_W-1:0] OP_LW    = 6'h23,
  parameter logic [OP_W-1:0] OP_SW    = 6'h2B,
  parameter logic [OP_W-1:0] OP_BEQ   = 6'h04,
  parameter logic [OP_W-1:0] OP_J     = 6'h02,
  parameter logic [OP_W-1:0] OP_ADDI  = 6'h08
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic            illegal_op,
  output logic [3:0]      state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   decode_illegal;

  // Write strobes before reset gating.
  logic   pc_write_raw, pc_write_cond_raw, mem_write_raw, ir_write_raw, reg_write_raw;

  // Handshake: memory holds a request (mem_read/mem_write) until mem_ready is
  // seen high in the same cycle; that cycle completes the transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      illegal_op <= 1'b0;
    end else begin
      state_q    <= state_d;
      illegal_op <= decode_illegal;
    end
  end

  always_comb begin
    state_d           = S_FETCH;
    decode_illegal    = 1'b0;
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    iord              = 1'b0;
    mem_read          = 1'b0;
    mem_to_reg        = 1'b0;
    reg_dst           = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'b00;
    alu_op            = 2'b00;
    pc_source         = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read     = 1'b1;
        alu_src_b    = 2'b01;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
        state_d      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_BEQ:       state_d = S_BEQ_EX;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            state_d        = S_FETCH;
            decode_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      S_MEMWR: begin
        mem_write_raw = 1'b1;
        iord          = 1'b1;
        state_d       = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
      end
      S_BEQ_EX: begin
        alu_src_a         = 1'b1;
        alu_op            = 2'b01;
        pc_write_cond_raw = 1'b1;
        pc_source         = 2'b01;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_raw = 1'b1;
      end
      S_JUMP: begin
        pc_write_raw = 1'b1;
        pc_source    = 2'b10;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces FETCH asynchronously; masking the strobes keeps a FETCH
  // with mem_ready high from loading PC/IR while reset is still asserted.
  assign pc_write      = pc_write_raw      & ~reset;
  assign pc_write_cond = pc_write_cond_raw & ~reset;
  assign mem_write     = mem_write_raw     & ~reset;
  assign ir_write      = ir_write_raw      & ~reset;
  assign reg_write     = reg_write_raw     & ~reset;

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Random instruction stream with random memory stalls and occasional async
// resets, checked cycle by cycle against a per-instruction state-list model.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0]}
  logic [15:0] dut_ctrl;
  assign dut_ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] cw(input logic pcw, pcc, io, mr, mw, irw, m2r, rd, rw, a,
                                     input logic [1:0] b, op, ps);
    return {pcw, pcc, io, mr, mw, irw, m2r, rd, rw, a, b, op, ps};
  endfunction

  // expected control word per state, from the per-state output rules
  logic [15:0] exp_tbl [16];
  initial begin
    for (int i = 0; i < 16; i++) exp_tbl[i] = '0;
    exp_tbl[0]  = cw(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00);
    exp_tbl[1]  = cw(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00);
    exp_tbl[2]  = cw(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
    exp_tbl[3]  = cw(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
    exp_tbl[4]  = cw(0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00);
    exp_tbl[5]  = cw(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
    exp_tbl[6]  = cw(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00);
    exp_tbl[7]  = cw(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00);
    exp_tbl[8]  = cw(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01);
    exp_tbl[9]  = cw(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
    exp_tbl[10] = cw(0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00);
    exp_tbl[11] = cw(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10);
  end

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = 6'h00;
      1: op = 6'h23;
      2: op = 6'h2B;
      3: op = 6'h04;
      4: op = 6'h02;
      5: op = 6'h08;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (is_legal(op)) op = 6'($urandom_range(0, 63));
      end
    endcase
    return op;
  endfunction

  // scoreboard: remaining states of the instruction in flight
  logic [3:0] exp_q[$];
  logic [5:0] cur_op;
  logic [3:0] cur;
  logic [15:0] exp_ctrl;
  logic       exp_illegal;

  task automatic load_instr(input logic [5:0] op);
    exp_q = '{4'd0, 4'd1};
    case (op)
      6'h23: begin exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
      6'h2B: begin exp_q.push_back(4'd2); exp_q.push_back(4'd5); end
      6'h00: begin exp_q.push_back(4'd6); exp_q.push_back(4'd7); end
      6'h08: begin exp_q.push_back(4'd9); exp_q.push_back(4'd10); end
      6'h04: exp_q.push_back(4'd8);
      6'h02: exp_q.push_back(4'd11);
      default: ;
    endcase
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'h00;
    exp_illegal = 1'b0;
    #2;
    check("reset_state", 32'(state), 32'd0);
    check("reset_illegal", 32'(illegal_op), 32'd0);
    check("reset_strobes", 32'({pc_write, ir_write, mem_write, reg_write, pc_write_cond}), 32'd0);
    #1 reset = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        cur_op = pick_op();
        load_instr(cur_op);
      end
      opcode    = cur_op;
      mem_ready = ($urandom_range(0, 3) != 0);
      #1;
      cur      = exp_q[0];
      exp_ctrl = exp_tbl[cur];
      if (cur == 4'd0) begin
        exp_ctrl[15] = mem_ready;
        exp_ctrl[10] = mem_ready;
      end
      check("state", 32'(state), 32'(cur));
      check("ctrl", 32'(dut_ctrl), 32'(exp_ctrl));
      check("illegal_op", 32'(illegal_op), 32'(exp_illegal));

      if ($urandom_range(0, 59) == 0) begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_strobes",
              32'({pc_write, ir_write, mem_write, reg_write, pc_write_cond}), 32'd0);
        check("async_rst_illegal", 32'(illegal_op), 32'd0);
        #1 reset = 1'b0;
        exp_q.delete();
        exp_illegal = 1'b0;
      end else begin
        exp_illegal = (cur == 4'd1) && !is_legal(cur_op);
        if (!((cur == 4'd0 || cur == 4'd3 || cur == 4'd5) && !mem_ready))
          void'(exp_q.pop_front());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
